// File: rtl/sram_frame_reader.sv
// Raster-scans an IMG_W x IMG_H frame out of a single-port SRAM into a valid/ready pixel stream.
// Optional build macro READER_VFLIP_EN scans rows bottom-to-top.
module sram_frame_reader #(
    parameter int IMG_W     = 1024,
    parameter int IMG_H     = 1024,
    parameter int ADDR_SZ   = 20,
    parameter int RAM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [ADDR_SZ-1:0]   sram_addr,
    output logic [RAM_WIDTH-1:0] sram_din,
    input  logic [RAM_WIDTH-1:0] sram_dout,
    output logic [RAM_WIDTH-1:0] pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 pix_eol,
    output logic                 pix_eof
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
`ifdef READER_VFLIP_EN
    localparam logic [YW-1:0] Y_FIRST = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_LAST  = '0;
`else
    localparam logic [YW-1:0] Y_FIRST = '0;
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t               state, next_state;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic                 inflight, inflight_eol, inflight_eof;
    logic [1:0]           fifo_cnt;
    logic [RAM_WIDTH-1:0] head_data, tail_data;
    logic                 head_eol, head_eof, tail_eol, tail_eof;
    logic                 line_end, frame_end, pop, issue;
    logic [1:0]           room;

    assign line_end  = (x == X_LAST);
    assign frame_end = line_end && (y == Y_LAST);
    assign pix_valid = (fifo_cnt != 2'd0);
    assign pop       = pix_valid && pix_ready;
    // Slots committed after this cycle: stored pixels plus the read in flight, less the one leaving.
    assign room      = fifo_cnt + {1'b0, inflight} - {1'b0, pop};

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            IDLE:    if (start) next_state = READ;
            READ: begin
                issue = (room < 2'd2);
                if (issue && frame_end) next_state = DRAIN;
            end
            DRAIN:   if (fifo_cnt == 2'd0 && !inflight) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (state == IDLE && start) begin
            x <= '0;
            y <= Y_FIRST;
        end else if (issue) begin
            if (line_end) begin
                x <= '0;
`ifdef READER_VFLIP_EN
                y <= y - YW'(1);
`else
                y <= y + YW'(1);
`endif
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Tags travel alongside the read so they land in the FIFO with their pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight     <= 1'b0;
            inflight_eol <= 1'b0;
            inflight_eof <= 1'b0;
        end else begin
            inflight     <= issue;
            inflight_eol <= line_end;
            inflight_eof <= frame_end;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_cnt  <= '0;
            head_data <= '0;
            head_eol  <= 1'b0;
            head_eof  <= 1'b0;
            tail_data <= '0;
            tail_eol  <= 1'b0;
            tail_eof  <= 1'b0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        head_data <= sram_dout;
                        head_eol  <= inflight_eol;
                        head_eof  <= inflight_eof;
                    end else begin
                        tail_data <= sram_dout;
                        tail_eol  <= inflight_eol;
                        tail_eof  <= inflight_eof;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_eol  <= tail_eol;
                    head_eof  <= tail_eof;
                    fifo_cnt  <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        head_data <= sram_dout;
                        head_eol  <= inflight_eol;
                        head_eof  <= inflight_eof;
                    end else begin
                        head_data <= tail_data;
                        head_eol  <= tail_eol;
                        head_eof  <= tail_eof;
                        tail_data <= sram_dout;
                        tail_eol  <= inflight_eol;
                        tail_eof  <= inflight_eof;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == READ) || (state == DRAIN);
    assign done      = (state == DONE);
    assign sram_en   = issue;
    assign sram_we   = 1'b0;
    assign sram_din  = '0;
    assign sram_addr = issue ? (ADDR_SZ'(y) * ADDR_SZ'(IMG_W) + ADDR_SZ'(x)) : '0;
    assign pix_data  = head_data;
    assign pix_eol   = pix_valid && head_eol;
    assign pix_eof   = pix_valid && head_eof;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Self-checking bench for sram_frame_reader on a 4x3 frame with a behavioural SRAM and raster-order model.
// Honours READER_VFLIP_EN when the design is built with it.
module tb_sram_frame_reader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = W * H;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_eol;
    logic          pix_eof;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            exp_addr [N];
    bit            exp_eol  [N];
    bit            exp_eof  [N];
    int            total = 0;
    int            bad   = 0;

    typedef struct {
        bit start;
        bit ready;
        bit busy;
        bit en;
        int iss;
        bit valid;
        int ord;
        bit done;
    } vec_t;
    vec_t vecs [18];

    sram_frame_reader #(.IMG_W(W), .IMG_H(H), .ADDR_SZ(AW), .RAM_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_eol(pix_eol), .pix_eof(pix_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (sram_en && !sram_we) sram_dout <= mem[sram_addr];
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void buildOrder();
        int k = 0;
        for (int r = 0; r < H; r++) begin
`ifdef READER_VFLIP_EN
            int row = H - 1 - r;
`else
            int row = r;
`endif
            for (int c = 0; c < W; c++) begin
                exp_addr[k] = row * W + c;
                exp_eol[k]  = (c == W - 1);
                exp_eof[k]  = (r == H - 1) && (c == W - 1);
                k++;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit r);
        @(posedge clk);
        #1;
        start     = s;
        pix_ready = r;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},  busy, 0);
        checkOutput({tag, "_done"},  done, 0);
        checkOutput({tag, "_en"},    sram_en, 0);
        checkOutput({tag, "_we"},    sram_we, 0);
        checkOutput({tag, "_addr"},  sram_addr, 0);
        checkOutput({tag, "_din"},   sram_din, 0);
        checkOutput({tag, "_valid"}, pix_valid, 0);
        checkOutput({tag, "_data"},  pix_data, 0);
        checkOutput({tag, "_eol"},   pix_eol, 0);
        checkOutput({tag, "_eof"},   pix_eof, 0);
    endtask

    // Mode 0: always ready; 1: 1,0,0,1 pattern; 2: random; 3: held off for the first 13 cycles.
    function automatic bit readyFor(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       return $urandom_range(0, 3) != 0;
            default: return cyc >= 13;
        endcase
    endfunction

    task automatic runFrame(input int mode, input bit noise);
        int            cyc = 0, popped = 0, issued = 0, dones = 0, after = 0;
        bit            seen_done = 0, prev_stall = 0, prev_eol = 0, prev_eof = 0;
        logic [DW-1:0] prev_data = '0;
        while (cyc < 300 && after < 4) begin
            applyStimulus((cyc == 0) || (noise && cyc <= 16), readyFor(mode, cyc));
            @(negedge clk);
            if (prev_stall) begin
                checkOutput("stall_valid", pix_valid, 1);
                checkOutput("stall_data", pix_data, prev_data);
                checkOutput("stall_eol", pix_eol, prev_eol);
                checkOutput("stall_eof", pix_eof, prev_eof);
            end
            if (pix_valid && pix_ready) begin
                if (popped < N) begin
                    checkOutput($sformatf("pix%0d_data", popped), pix_data, mem[exp_addr[popped]]);
                    checkOutput($sformatf("pix%0d_eol", popped), pix_eol, exp_eol[popped]);
                    checkOutput($sformatf("pix%0d_eof", popped), pix_eof, exp_eof[popped]);
                end else begin
                    checkOutput("extra_pixel", popped + 1, N);
                end
                popped++;
            end
            if (sram_en) begin
                if (issued < N) checkOutput($sformatf("issue%0d_addr", issued), sram_addr, exp_addr[issued]);
                else            checkOutput("extra_issue", issued + 1, N);
                issued++;
            end
            if (sram_we) checkOutput("sram_we", 1, 0);
            checkOutput("outstanding_le2", int'(issued - popped <= 2), 1);
            if (mode == 3 && cyc == 12) checkOutput("stall_issues_le2", int'(issued <= 2), 1);
            if (seen_done) begin
                checkOutput("post_done_busy", busy, 0);
                checkOutput("post_done_en", sram_en, 0);
                checkOutput("post_done_valid", pix_valid, 0);
                after++;
            end
            if (done) begin
                dones++;
                seen_done = 1;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_eol   = pix_eol;
            prev_eof   = pix_eof;
            cyc++;
        end
        if (!seen_done) checkOutput("done_timeout", 0, 1);
        checkOutput("frame_pixels", popped, N);
        checkOutput("frame_issues", issued, N);
        checkOutput("done_pulses", dones, 1);
    endtask

    task automatic runTable();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].start, vecs[i].ready);
            @(negedge clk);
            checkOutput($sformatf("tbl%0d_busy", i), busy, vecs[i].busy);
            checkOutput($sformatf("tbl%0d_en", i), sram_en, vecs[i].en);
            checkOutput($sformatf("tbl%0d_valid", i), pix_valid, vecs[i].valid);
            checkOutput($sformatf("tbl%0d_done", i), done, vecs[i].done);
            if (vecs[i].iss >= 0)
                checkOutput($sformatf("tbl%0d_addr", i), sram_addr, exp_addr[vecs[i].iss]);
            if (vecs[i].ord >= 0) begin
                checkOutput($sformatf("tbl%0d_data", i), pix_data, mem[exp_addr[vecs[i].ord]]);
                checkOutput($sformatf("tbl%0d_eol", i), pix_eol, exp_eol[vecs[i].ord]);
                checkOutput($sformatf("tbl%0d_eof", i), pix_eof, exp_eof[vecs[i].ord]);
            end
        end
    endtask

    initial begin
        bit found = 0;
        rst       = 1'b1;
        start     = 1'b0;
        pix_ready = 1'b0;
        sram_dout = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        buildOrder();

        // Start in cycle 0: reads issue in cycles 1..12, pixels valid in cycles 3..14, done in 16.
        vecs[0]  = '{1, 1, 0, 0, -1, 0, -1, 0};
        vecs[1]  = '{0, 1, 1, 1,  0, 0, -1, 0};
        vecs[2]  = '{0, 1, 1, 1,  1, 0, -1, 0};
        for (int c = 3; c <= 12; c++) vecs[c] = '{0, 1, 1, 1, c - 1, 1, c - 3, 0};
        vecs[13] = '{0, 1, 1, 0, -1, 1, 10, 0};
        vecs[14] = '{0, 1, 1, 0, -1, 1, 11, 0};
        vecs[15] = '{0, 1, 1, 0, -1, 0, -1, 0};
        vecs[16] = '{0, 1, 0, 0, -1, 0, -1, 1};
        vecs[17] = '{0, 1, 0, 0, -1, 0, -1, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        runTable();
        runFrame(1, 0);
        runFrame(3, 0);

        // Reset while pixel 5 is at the head, then restart from pixel 0.
        applyStimulus(1, 1);
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (pix_valid && pix_data == mem[exp_addr[5]]) found = 1;
            else applyStimulus(0, 1);
        end
        if (!found) checkOutput("rst_head5_timeout", 0, 1);
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("midrst");
        rst = 1'b0;
        runFrame(0, 0);

        runFrame(0, 1);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
            runFrame(2, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
